// File: rtl/enemy_motion.sv
// Per-enemy chase/attack/death controller for boxhead, clocked once per video frame.
// Steps toward the player on one axis every MOVE_DIV frames and emits registered position, motion and facing.
module enemy_motion #(
  parameter logic [8:0] SPAWN_X  = 9'd16,
  parameter logic [8:0] SPAWN_Y  = 9'd16,
  parameter logic [8:0] X_MIN    = 9'd0,
  parameter logic [8:0] X_MAX    = 9'd304,
  parameter logic [8:0] Y_MIN    = 9'd0,
  parameter logic [8:0] Y_MAX    = 9'd224,
  parameter logic [8:0] STEP     = 9'd1,
  parameter int         MOVE_DIV = 2,
  parameter logic [7:0] COOLDOWN = 8'd60,
  parameter logic [3:0] MAX_HP   = 4'd3
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Spawn,
  input  logic       Hit,
  output logic [8:0] Obj_X_Pos,
  output logic [8:0] Obj_Y_Pos,
  output logic [8:0] Obj_X_Motion,
  output logic [8:0] Obj_Y_Motion,
  output logic [1:0] Obj_Dir,
  output logic       Alive,
  output logic       Attack,
  output logic [3:0] HP,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {S_DEAD = 2'd0, S_CHASE = 2'd1, S_ATTACK = 2'd2} state_t;

  state_t      state_q;
  logic [8:0]  x_q, y_q, xm_q, ym_q;
  logic [1:0]  dir_q;
  logic        alive_q, attack_q;
  logic [3:0]  hp_q;
  logic [7:0]  div_q, cool_q;

  // Step candidate, evaluated from the registered position every frame
  logic signed [9:0]  dx, dy, d_sel;
  logic        [9:0]  adx, ady, a_sel, mag;
  logic               use_x, contact, step_now;
  logic signed [10:0] cur, nxt, lo, hi;
  logic        [8:0]  delta_d, coord_d;
  logic        [1:0]  dir_d;

  always_comb begin
    dx      = $signed({1'b0, Player_X}) - $signed({1'b0, x_q});
    dy      = $signed({1'b0, Player_Y}) - $signed({1'b0, y_q});
    adx     = dx[9] ? 10'(-dx) : 10'(dx);
    ady     = dy[9] ? 10'(-dy) : 10'(dy);
    use_x   = (adx >= ady);
    d_sel   = use_x ? dx : dy;
    a_sel   = use_x ? adx : ady;
    mag     = (a_sel > {1'b0, STEP}) ? {1'b0, STEP} : a_sel;
    cur     = use_x ? $signed({2'b0, x_q}) : $signed({2'b0, y_q});
    lo      = use_x ? $signed({2'b0, X_MIN}) : $signed({2'b0, Y_MIN});
    hi      = use_x ? $signed({2'b0, X_MAX}) : $signed({2'b0, Y_MAX});
    nxt     = d_sel[9] ? (cur - $signed({1'b0, mag})) : (cur + $signed({1'b0, mag}));
    if (nxt < lo) nxt = lo;
    if (nxt > hi) nxt = hi;
    delta_d = 9'(nxt - cur);
    coord_d = nxt[8:0];
    dir_d   = dir_q;
    if (delta_d != 9'd0) begin
      if (use_x) dir_d = delta_d[8] ? 2'd3 : 2'd1;
      else       dir_d = delta_d[8] ? 2'd0 : 2'd2;
    end
    contact  = (x_q == Player_X) && (y_q == Player_Y);
    step_now = (div_q == 8'(MOVE_DIV - 1));
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q  <= S_DEAD;
      x_q      <= SPAWN_X;
      y_q      <= SPAWN_Y;
      xm_q     <= 9'd0;
      ym_q     <= 9'd0;
      dir_q    <= 2'd2;
      alive_q  <= 1'b0;
      attack_q <= 1'b0;
      hp_q     <= 4'd0;
      div_q    <= 8'd0;
      cool_q   <= 8'd0;
    end else begin
      attack_q <= 1'b0;
      case (state_q)
        S_DEAD: begin
          if (Spawn) begin
            state_q <= S_CHASE;
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            xm_q    <= 9'd0;
            ym_q    <= 9'd0;
            hp_q    <= MAX_HP;
            alive_q <= 1'b1;
            div_q   <= 8'd0;
          end
        end
        default: begin
          if (Hit) begin
            xm_q <= 9'd0;
            ym_q <= 9'd0;
            if (hp_q == 4'd1) begin
              state_q <= S_DEAD;
              alive_q <= 1'b0;
              hp_q    <= 4'd0;
              x_q     <= SPAWN_X;
              y_q     <= SPAWN_Y;
            end else begin
              hp_q <= hp_q - 4'd1;
            end
          end else if (state_q == S_CHASE) begin
            if (contact) begin
              state_q  <= S_ATTACK;
              attack_q <= 1'b1;
              cool_q   <= COOLDOWN;
              xm_q     <= 9'd0;
              ym_q     <= 9'd0;
            end else if (step_now) begin
              div_q <= 8'd0;
              dir_q <= dir_d;
              if (use_x) begin
                x_q  <= coord_d;
                xm_q <= delta_d;
                ym_q <= 9'd0;
              end else begin
                y_q  <= coord_d;
                ym_q <= delta_d;
                xm_q <= 9'd0;
              end
            end else begin
              div_q <= div_q + 8'd1;
              xm_q  <= 9'd0;
              ym_q  <= 9'd0;
            end
          end else begin
            // Player movement during cooldown is only looked at once it expires
            xm_q <= 9'd0;
            ym_q <= 9'd0;
            if (cool_q == 8'd0) begin
              if (contact) begin
                attack_q <= 1'b1;
                cool_q   <= COOLDOWN;
              end else begin
                state_q <= S_CHASE;
                div_q   <= 8'd0;
              end
            end else begin
              cool_q <= cool_q - 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign Obj_X_Pos    = x_q;
  assign Obj_Y_Pos    = y_q;
  assign Obj_X_Motion = xm_q;
  assign Obj_Y_Motion = ym_q;
  assign Obj_Dir      = dir_q;
  assign Alive        = alive_q;
  assign Attack       = attack_q;
  assign HP           = hp_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/enemy_motion.md
# enemy_motion

Per-enemy movement and combat controller for boxhead. It advances one enemy's position toward the player once every MOVE_DIV frames and produces the position/motion/direction stream that the enemy animation controller and sprite drawer consume. It also tracks hit points, contact attacks and death/respawn. All logic is clocked on frame_clk, so one cycle equals one video frame.

## Interface
- SPAWN_X, 9'd16, X coordinate loaded on spawn and reset
- SPAWN_Y, 9'd16, Y coordinate loaded on spawn and reset
- X_MIN / X_MAX, 9'd0 / 9'd304, inclusive X clamp bounds
- Y_MIN / Y_MAX, 9'd0 / 9'd224, inclusive Y clamp bounds
- STEP, 9'd1, maximum pixels moved per move frame (≥1)
- MOVE_DIV, 2, move once every MOVE_DIV frames (≥1)
- COOLDOWN, 8'd60, frames between successive attacks
- MAX_HP, 4'd3, hit points on spawn (≥1)
- frame_clk  in  1  sole clock, one rising edge per frame
- Reset_n  in  1  synchronous, active-low reset
- Player_X, Player_Y  in  9  player position, unsigned
- Spawn  in  1  one-cycle request to (re)spawn
- Hit  in  1  one-cycle bullet-hit strobe
- Obj_X_Pos, Obj_Y_Pos  out  9  enemy position, unsigned
- Obj_X_Motion, Obj_Y_Motion  out  9  two's-complement delta applied at the last edge
- Obj_Dir  out  2  facing: 0 up, 1 right, 2 down, 3 left
- Alive  out  1  enemy active
- Attack  out  1  one-cycle attack pulse
- HP  out  4  remaining hit points

## Operation
- States: S_DEAD, S_CHASE, S_ATTACK. Reset_n=0 at an edge gives:
  - State S_DEAD.
  - Pos = (SPAWN_X, SPAWN_Y). Motion = 0. Obj_Dir = 2.
  - Alive = 0. Attack = 0. HP = 0. Move-divider count = 0. Cooldown = 0.
  - Reset overrides all other inputs, including mid-attack.
- Contact = (Obj_X_Pos == Player_X) && (Obj_Y_Pos == Player_Y), evaluated on the current registered position.
- S_DEAD:
  - Hit is ignored.
  - Spawn=1 → S_CHASE. Load pos to spawn, HP = MAX_HP, Alive = 1, divider = 0, motion = 0.
- S_CHASE, checked in priority order:
  - (1) Hit: HP−1. If the old HP was 1 → S_DEAD, Alive = 0, HP = 0, pos = spawn. No movement on a hit frame. Motion = 0.
  - (2) Contact → S_ATTACK. Attack = 1, cooldown = COOLDOWN, motion = 0.
  - (3) Otherwise the divider increments. When divider == MOVE_DIV−1 it wraps to 0 and a step is applied. On non-step frames motion = 0.
- Step rule:
  - dx = Player_X − X and dy = Player_Y − Y, computed as 10-bit signed.
  - Axis = X if |dx| ≥ |dy| (a tie goes to X), else Y.
  - Magnitude = min(|d|, STEP), so the enemy never overshoots. Sign = sign(d).
  - The new coordinate is clamped to [MIN, MAX]. Motion reports the actually applied delta after clamping.
  - The unused axis gets motion 0.
  - Obj_Dir updates only when the applied delta is nonzero: +X → 1, −X → 3, +Y → 2, −Y → 0.
- S_ATTACK:
  - Motion = 0. Attack = 0 except on re-attack. Cooldown decrements each frame.
  - Hit is handled the same as in S_CHASE and takes priority over cooldown handling.
  - When cooldown == 0 and contact holds: Attack = 1, cooldown = COOLDOWN, stay in S_ATTACK.
  - When cooldown == 0 and no contact: → S_CHASE, divider = 0.
- Spawn is ignored while Alive. If Spawn and Hit arrive together in S_DEAD, Spawn wins.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected in outputs after edge N.
- Move cadence: the first step after spawn lands MOVE_DIV edges after the spawn edge.
- Attack pulse:
  - High exactly one cycle, beginning at the edge after contact is first seen in S_CHASE.
  - Re-attacks while contact holds are spaced COOLDOWN+1 cycles apart.
- Death: Alive falls at the edge that samples the final Hit. Respawn needs a later Spawn.
- The player moving during the cooldown has no effect until the cooldown expires.

## Test plan
- Reset then spawn: Reset_n=0 for 2 cycles, then Spawn pulse → pos (16,16), HP=3, Alive=1, Obj_Dir=2, motion 0.
- Chase: player at (20,18), MOVE_DIV=2, STEP=1 → X increments every 2nd frame (dir 1, X_Motion=+1) until dx=2=dy. The tie then steps X again. Expected pos sequence ends at (20,18).
- Overshoot/clamp: STEP=4, enemy (300,100), player (310,100) → next step X=304, X_Motion=+4, then motion 0 on every later frame.
- Contact attack: enemy reaches player → Attack high for 1 cycle. Holding contact gives the next pulse 61 cycles later. Moving the player away during cooldown returns to S_CHASE when cooldown hits 0.
- Hits: 3 Hit pulses while chasing → HP 2,1,0, Alive=0 after the third, no movement on hit frames. Hit in S_DEAD → no change. Spawn+Hit together in S_DEAD → spawn with HP=3.
- Reset mid-attack: Reset_n=0 during S_ATTACK → all outputs at reset values next cycle, Attack=0.
